dispense_tracker: RTL
=====================

# dispense_tracker

Receiving end of the vending machine's dispense and change outputs. Sits downstream of the vending controller and consumes its held-level product lines `OUT[3:0]` and change lines `VF[2:0]`. Counts each dispense and change event exactly once, keeps per-product stock with restock loading, and accumulates the change paid out. Drives a sold-out mask and a sticky protocol-error flag back toward the selection panel.

## Interface
- `STOCK_W`, default 4: width of each stock counter.
- `MAX_STOCK`, default 15: saturation ceiling for restock. Must be ≤ 2^STOCK_W−1.
- `RESET_STOCK`, default 5: stock value of every product after reset.
- `HOLD_MAX`, default 20: maximum cycles a dispense level may stay asserted.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `OUT` in 4: one-hot dispense level from the controller, held for multiple cycles.
- `VF` in 3: one-hot change level. Bit 0 = 1 unit, bit 1 = 2 units, bit 2 = 4 units.
- `load` in 1: one-cycle restock strobe.
- `load_sel` in 2: product index to restock.
- `load_qty` in STOCK_W: quantity to add.
- `clear_err` in 1: one-cycle strobe that leaves FAULT.
- `rd_sel` in 2: stock read index.
- `rd_stock` out STOCK_W: registered stock of product `rd_sel`, one cycle latency.
- `soldout` out 4: bit i = 1 when stock[i] == 0. Registered.
- `ack` out 1: one-cycle pulse per accepted dispense.
- `coins_out` out 8: total change units paid, saturating at 255.
- `err` out 1: sticky; high while in FAULT.

## Operation
- Registers: `out_q[3:0]`, `vf_q[2:0]` (last-cycle samples), `stock[0..3]`, `hold_cnt` (8 bit), 2-bit state.
- States: IDLE, BUSY, FAULT.
- IDLE:
  - `OUT` one-hot with `out_q == 0` → decrement `stock[i]` if nonzero, pulse `ack`, clear `hold_cnt`, go BUSY.
  - If `stock[i] == 0`, do not decrement, do not pulse `ack`; go FAULT (dispense of sold-out item).
- BUSY:
  - `OUT == 0` → IDLE.
  - `OUT` equal to `out_q` → `hold_cnt++`. If `hold_cnt` reaches `HOLD_MAX` → FAULT.
  - `OUT` changes to a different nonzero value without returning to 0 → FAULT. No decrement.
- Any state: `OUT` with more than one bit set → FAULT, no decrement.
- FAULT:
  - No further stock decrements or `ack`.
  - Change counting and restock continue.
  - `clear_err` → IDLE, but only when `OUT == 0`; otherwise stay in FAULT.
- Change counting:
  - A rising edge of one-hot `VF` (`vf_q == 0`, `VF != 0`) adds 1, 2 or 4 to `coins_out`, saturating at 255.
  - Multi-hot `VF` → FAULT, no add.
  - A level held N cycles counts once.
- Restock: on `load`, `stock[load_sel] <= min(stock + load_qty, MAX_STOCK)`, computed at STOCK_W+1 bits.
- Restock and accepted dispense on the same product in the same cycle: result = min(stock + qty, MAX_STOCK) − 1. The sold-out check uses the pre-load value.
- `soldout`, `rd_stock` and `coins_out` are registered from next-state values. Each reflects an event in the cycle after the triggering edge.

## Timing
- Reset (async) values:
  - every `stock` = RESET_STOCK.
  - `soldout` = 4'b0000 if RESET_STOCK > 0, otherwise 4'b1111.
  - `ack` = 0, `coins_out` = 0, `err` = 0.
  - state IDLE; `out_q`, `vf_q`, `hold_cnt` = 0.
  - `rd_stock` = RESET_STOCK.
- Dispense: `OUT` first sampled nonzero at edge k → `ack` high for cycle k..k+1 only. `stock` and `soldout` updated at edge k.
- `err` rises at the edge where the fault condition is sampled.
- `err` falls at the edge sampling `clear_err` with `OUT == 0`.
- Reset mid-BUSY: everything returns to reset values immediately. If `OUT` is still held when reset releases, it is treated as a new edge, because `out_q` = 0.
- Counters never wrap. `stock` floors at 0, `coins_out` caps at 255.

## Test plan
- Reset, then `OUT=4'b0010` held 10 cycles, then 0 → exactly one `ack`; `stock[1]` 5→4; `soldout=0`; `err=0`.
- Five dispenses of product 0, then a sixth → `stock[0]=0`, `soldout[0]=1` after the fifth; the sixth gives no `ack`, `err=1`; `clear_err` with `OUT=0` → `err=0`.
- `VF=3'b010` held 8 cycles, then `3'b001`, then `3'b100` → `coins_out` = 2, 3, 7. Continue to 253 then add 4 → saturates at 255.
- `load` with `load_sel=2`, `load_qty=12` on stock 5 → `stock[2]=15` (capped). Same cycle as an accepted dispense on product 2 → 14.
- `OUT=4'b0101` → `err=1`, no stock change. Separately, `OUT` held 21 cycles with HOLD_MAX=20 → `err=1` at the cycle where `hold_cnt` reaches 20.
- Assert `reset` while in BUSY with `OUT` held → all outputs reset immediately. After release, one new `ack` and `stock` = RESET_STOCK−1.

Source files
------------

// File: rtl/dispense_tracker.sv
// Receiving end of the vending controller's dispense and change levels: counts each
// event once, tracks per-product stock with restock, totals change paid, and flags protocol faults.
module dispense_tracker #(
  parameter int STOCK_W     = 4,
  parameter int MAX_STOCK   = 15,
  parameter int RESET_STOCK = 5,
  parameter int HOLD_MAX    = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         OUT,
  input  logic [2:0]         VF,
  input  logic               load,
  input  logic [1:0]         load_sel,
  input  logic [STOCK_W-1:0] load_qty,
  input  logic               clear_err,
  input  logic [1:0]         rd_sel,
  output logic [STOCK_W-1:0] rd_stock,
  output logic [3:0]         soldout,
  output logic               ack,
  output logic [7:0]         coins_out,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;

  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(RESET_STOCK);
  localparam logic [STOCK_W:0]   STOCK_CAP  = (STOCK_W+1)'(MAX_STOCK);

  state_t             state, state_next;
  logic [3:0]         out_q;
  logic [2:0]         vf_q;
  logic [7:0]         hold_cnt, hold_next;
  logic [STOCK_W-1:0] stock      [4];
  logic [STOCK_W-1:0] stock_next [4];
  logic [7:0]         coins_next;
  logic [8:0]         coins_sum;
  logic [STOCK_W:0]   restock_sum;
  logic [STOCK_W-1:0] restock_val;
  logic [1:0]         out_idx;
  logic               out_multi, out_rise, vf_multi, vf_rise, accept;

  assign out_multi = (OUT & (OUT - 4'd1)) != 4'd0;
  assign vf_multi  = (VF & (VF - 3'd1)) != 3'd0;
  assign out_rise  = (OUT != 4'd0) && (out_q == 4'd0) && !out_multi;
  assign vf_rise   = (VF != 3'd0) && (vf_q == 3'd0) && !vf_multi;
  assign err       = (state == FAULT);

  always_comb begin
    out_idx = 2'd0;
    case (OUT)
      4'b0010: out_idx = 2'd1;
      4'b0100: out_idx = 2'd2;
      4'b1000: out_idx = 2'd3;
      default: out_idx = 2'd0;
    endcase
  end

  // Next state; a multi-hot change level overrides everything, including a dispense in the same cycle.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (out_multi) begin
          state_next = FAULT;
        end else if (out_rise) begin
          if (stock[out_idx] != '0) begin
            accept     = 1'b1;
            hold_next  = 8'd0;
            state_next = BUSY;
          end else begin
            state_next = FAULT;
          end
        end
      end
      BUSY: begin
        if (out_multi) begin
          state_next = FAULT;
        end else if (OUT == 4'd0) begin
          state_next = IDLE;
        end else if (OUT == out_q) begin
          hold_next = hold_cnt + 8'd1;
          if (hold_next == 8'(HOLD_MAX)) state_next = FAULT;
        end else begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        if (clear_err && (OUT == 4'd0)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (vf_multi) begin
      state_next = FAULT;
      accept     = 1'b0;
    end
  end

  // Restock saturates before a same-cycle dispense takes one away.
  always_comb begin
    restock_sum = {1'b0, stock[load_sel]} + {1'b0, load_qty};
    restock_val = (restock_sum > STOCK_CAP) ? STOCK_CAP[STOCK_W-1:0] : restock_sum[STOCK_W-1:0];
    for (int i = 0; i < 4; i++) begin
      stock_next[i] = stock[i];
      if (load && (load_sel == 2'(i))) stock_next[i] = restock_val;
      if (accept && (out_idx == 2'(i))) stock_next[i] = stock_next[i] - STOCK_W'(1);
    end
  end

  always_comb begin
    coins_sum  = {1'b0, coins_out} + {6'd0, VF};
    coins_next = coins_out;
    if (vf_rise) coins_next = coins_sum[8] ? 8'hFF : coins_sum[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_q     <= 4'd0;
      vf_q      <= 3'd0;
      hold_cnt  <= 8'd0;
      ack       <= 1'b0;
      coins_out <= 8'd0;
      soldout   <= (RESET_STOCK > 0) ? 4'b0000 : 4'b1111;
      rd_stock  <= STOCK_INIT;
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
    end else begin
      state     <= state_next;
      out_q     <= OUT;
      vf_q      <= VF;
      hold_cnt  <= hold_next;
      ack       <= accept;
      coins_out <= coins_next;
      rd_stock  <= stock_next[rd_sel];
      for (int i = 0; i < 4; i++) begin
        stock[i]   <= stock_next[i];
        soldout[i] <= (stock_next[i] == '0);
      end
    end
  end

endmodule
